// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the instruction encoder slice.
//   opcode_t   - RV32I major opcodes understood by the encoder (plus HALT)
//   word_t     - 32-bit instruction/data word
//   enc_req_t  - packed encoder request (opcode, registers, functs, immediate)
//   NOP_INSTR / HALT_INSTR - fixed words substituted by the encoder
//   imm_fits() - true when imm[31:lsb] are all equal (sign-extension check)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [6:0] {
    RTYPE    = 7'b0110011,
    ITYPE    = 7'b0010011,
    ITYPE_LW = 7'b0000011,
    JALR     = 7'b1100111,
    STYPE    = 7'b0100011,
    BTYPE    = 7'b1100011,
    JAL      = 7'b1101111,
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    HALT     = 7'b1111111
  } opcode_t;

  localparam word_t NOP_INSTR  = 32'h00000013;
  localparam word_t HALT_INSTR = 32'hFFFFFFFF;

  // opcode is kept as raw bits so that unknown encodings can be flagged
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    word_t      imm;
  } enc_req_t;

  // An arithmetic shift leaves all-zeros or all-ones exactly when the
  // discarded upper bits are a pure sign extension of bit lsb.
  function automatic logic imm_fits(input word_t imm, input int unsigned lsb);
    logic signed [31:0] t;
    t = $signed(imm) >>> lsb;
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two, >= 2).
//   clk, rst      - clock, asynchronous active-high reset
//   push, din     - write request / data (ignored while full)
//   pop, dout     - read request / head data (dout is 0 while empty)
//   count         - number of stored entries (0..DEPTH)
//   full, empty   - occupancy flags
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  // Head is forced to zero when empty so stale words never show on the outputs
  assign dout      = empty ? '0 : mem_r[rd_ptr_r];

  // Storage array write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers (wrap naturally since DEPTH is a power of two) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode/register/funct/immediate fields into an RV32I
// instruction word, flagging immediates that cannot be encoded (word becomes
// NOP). Results are buffered in an output FIFO; no combinational in->out path.
//   CLK, RST                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - request handshake (in_ready low while full or RST)
//   in_opcode,in_rd,in_rs1,in_rs2,in_funct3,in_funct7,in_imm - request fields
//   out_valid/out_ready      - buffered word handshake
//   out_instr, out_err       - encoded word and "not encodable" flag
//   err_count [15:0]         - saturating count of accepted error requests,
//                              present only when ENC_ERR_COUNT_EN is defined
module instr_encoder
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
`ifdef ENC_ERR_COUNT_EN
  output logic [15:0] err_count,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  enc_req_t                req_s;
  word_t                   instr_s;
  logic                    err_s;
  logic                    push_s;
  logic                    full_s;
  logic                    empty_s;
  logic [32:0]             head_s;
  logic [$clog2(DEPTH):0]  count_s;

  assign req_s.opcode = in_opcode;
  assign req_s.rd     = in_rd;
  assign req_s.rs1    = in_rs1;
  assign req_s.rs2    = in_rs2;
  assign req_s.funct3 = in_funct3;
  assign req_s.funct7 = in_funct7;
  assign req_s.imm    = in_imm;

  // Field packing and immediate range/alignment check
  always_comb begin
    instr_s = NOP_INSTR;
    err_s   = 1'b0;
    case (req_s.opcode)
      RTYPE: begin
        instr_s = {req_s.funct7, req_s.rs2, req_s.rs1, req_s.funct3, req_s.rd, req_s.opcode};
      end
      ITYPE, ITYPE_LW, JALR: begin
        if (imm_fits(req_s.imm, 11)) begin
          instr_s = {req_s.imm[11:0], req_s.rs1, req_s.funct3, req_s.rd, req_s.opcode};
        end else begin
          err_s = 1'b1;
        end
      end
      STYPE: begin
        if (imm_fits(req_s.imm, 11)) begin
          instr_s = {req_s.imm[11:5], req_s.rs2, req_s.rs1, req_s.funct3,
                     req_s.imm[4:0], req_s.opcode};
        end else begin
          err_s = 1'b1;
        end
      end
      BTYPE: begin
        if (imm_fits(req_s.imm, 12) && !req_s.imm[0]) begin
          instr_s = {req_s.imm[12], req_s.imm[10:5], req_s.rs2, req_s.rs1, req_s.funct3,
                     req_s.imm[4:1], req_s.imm[11], req_s.opcode};
        end else begin
          err_s = 1'b1;
        end
      end
      JAL: begin
        if (imm_fits(req_s.imm, 20) && !req_s.imm[0]) begin
          instr_s = {req_s.imm[20], req_s.imm[10:1], req_s.imm[11], req_s.imm[19:12],
                     req_s.rd, req_s.opcode};
        end else begin
          err_s = 1'b1;
        end
      end
      LUI, AUIPC: begin
        if (req_s.imm[11:0] == 12'd0) begin
          instr_s = {req_s.imm[31:12], req_s.rd, req_s.opcode};
        end else begin
          err_s = 1'b1;
        end
      end
      HALT: begin
        instr_s = HALT_INSTR;
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  // Ready depends only on occupancy, never on in_valid or a same-cycle pop
  assign in_ready  = !full_s && !RST;
  assign push_s    = in_valid && in_ready;
  assign out_valid = !empty_s;
  assign out_instr = head_s[31:0];
  assign out_err   = head_s[32];

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .din   ({err_s, instr_s}),
    .pop   (out_ready),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef ENC_ERR_COUNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of accepted requests that could not be encoded
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_r <= 16'd0;
    end else if (push_s && err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_HALT = 7'b1111111;
  localparam logic [6:0] OP_BAD  = 7'b0001111;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int NVEC = 18;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
`ifdef ENC_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [32:0] sb_q [$];
  logic [32:0] cur_exp;
  int          n_checks;
  int          n_fail;
  int          exp_err_cnt;

  instr_encoder #(.DEPTH(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
`ifdef ENC_ERR_COUNT_EN
    .err_count (err_count),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    cur_exp   = {v.exp_err, (v.exp_err ? NOP : v.exp_instr)};
  endtask

  // Called #1 after an edge: score what the next edge will do, then advance
  task automatic step();
    logic acc;
    logic pop;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
    if (pop && sb_q.size() != 0) begin
      check("out_instr", out_instr, sb_q[0][31:0]);
      check("out_err", {31'd0, out_err}, {31'd0, sb_q[0][32]});
      void'(sb_q.pop_front());
    end
    if (acc) begin
      sb_q.push_back(cur_exp);
      if (cur_exp[32] && exp_err_cnt < 65535) exp_err_cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{OP_I,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        1'b0, 32'h00500093};
    vecs[1]  = '{OP_B,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE000EE3};
    vecs[2]  = '{OP_LUI,  5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 32'h123452B7};
    vecs[3]  = '{OP_I,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     1'b1, 32'h0};
    vecs[4]  = '{OP_JAL,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        1'b1, 32'h0};
    vecs[5]  = '{OP_AUI,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 1'b1, 32'h0};
    vecs[6]  = '{OP_BAD,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        1'b1, 32'h0};
    vecs[7]  = '{OP_R,    5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 1'b0, 32'h002081B3};
    vecs[8]  = '{OP_S,    5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE20AE23};
    vecs[9]  = '{OP_JAL,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        1'b0, 32'h008000EF};
    vecs[10] = '{OP_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123, 1'b0, 32'hFFFFFFFF};
    vecs[11] = '{OP_JALR, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,        1'b0, 32'h00008067};
    vecs[12] = '{OP_I,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b0, 32'h80000093};
    vecs[13] = '{OP_LW,   5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4,        1'b0, 32'h00412283};
    vecs[14] = '{OP_B,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 1'b1, 32'h0};
    vecs[15] = '{OP_B,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        1'b1, 32'h0};
    vecs[16] = '{OP_AUI,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 1'b0, 32'h00001097};
    vecs[17] = '{OP_JAL,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE, 1'b0, 32'h7FFFF06F};

    n_checks = 0; n_fail = 0; exp_err_cnt = 0;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0; cur_exp = 33'd0;

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ENC_ERR_COUNT_EN
    check("rst_err_count", {16'd0, err_count}, 32'd0);
`endif

    // Table: back-to-back requests with a free-running consumer
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      step();
    end
    drain();
`ifdef ENC_ERR_COUNT_EN
    check("err_count", {16'd0, err_count}, exp_err_cnt);
`endif

    // Full FIFO: third request stalls, no pass-through while full and popping
    out_ready = 1'b0;
    drive(vecs[0]); step();
    drive(vecs[7]); step();
    drive(vecs[2]);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    out_ready = 1'b1;
    check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    drain();

    // Head stable under back-pressure, then simultaneous push and pop
    out_ready = 1'b0;
    drive(vecs[3]); step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_instr", out_instr, sb_q[0][31:0]);
      check("hold_err", {31'd0, out_err}, {31'd0, sb_q[0][32]});
      step();
    end
    drive(vecs[8]);
    out_ready = 1'b1;
    step();
    check("pushpop_count", {29'd0, dut.u_fifo.count}, 32'd1);
    drain();

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    drive(vecs[4]); step();
    drive(vecs[9]); step();
    in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_err", {31'd0, out_err}, 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    sb_q.delete();
    exp_err_cnt = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_count", {29'd0, dut.u_fifo.count}, 32'd0);
`ifdef ENC_ERR_COUNT_EN
    check("rel_err_count", {16'd0, err_count}, 32'd0);
`endif
    step();
    drive(vecs[1]); step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
